iob_bridge: RTL and testbench

//  Responder for selects from the address decoder. It runs a 68000-style cycle on the I/O bus (IOB) for

---
 rtl/iob_pkg.sv | 21 ++
 rtl/iob_eclk.sv | 37 +++
 rtl/iob_bridge.sv | 225 ++++++++++++++++++++++
 tb/tb_iob_bridge.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_pkg.sv
// Shared types and constants for the I/O bus bridge: FSM states and 6800 E-clock slot numbers.
package iob_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_STRB,
    ST_WAIT,
    ST_VSYNC,
    ST_VWAIT,
    ST_DATA,
    ST_NEG,
    ST_DONE
  } iob_state_t;

  localparam logic [3:0] E_HI_START = 4'd6;
  localparam logic [3:0] E_LAST     = 4'd9;
  localparam logic [3:0] VMA_SLOT   = 4'd3;
  localparam int         TO_W       = 8;

endpackage

// File: rtl/iob_eclk.sv
// IOB state tick divider and free-running 6800 E clock (10 ticks per period, 4 high / 6 low).
module iob_eclk
  import iob_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic       CLK,
  input  logic       RES,
  output logic       tick,
  output logic       E,
  output logic [3:0] ecount
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [DW-1:0] div_cnt;
  logic [3:0]    ecount_nxt;

  assign tick       = (div_cnt == DW'(DIV - 1));
  assign ecount_nxt = (ecount == E_LAST) ? 4'd0 : ecount + 4'd1;

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      div_cnt <= '0;
      ecount  <= 4'd0;
      E       <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        ecount <= ecount_nxt;
        E      <= (ecount_nxt >= E_HI_START);
      end
    end
  end

endmodule

// File: rtl/iob_bridge.sv
// Runs one 68000-style IOB cycle (DTACK, VPA/E or autovector IACK) per FSB select and returns
// a single termination pulse. All outputs are registered.
module iob_bridge
  import iob_pkg::*;
#(
  parameter int DIV     = 2,
  parameter int TIMEOUT = 255
) (
  input  logic       CLK,
  input  logic       RES,
  input  logic       IOREQ,
  input  logic       IACK,
  input  logic       RnW,
  input  logic [1:0] BE,
  output logic       IOACK,
  output logic       IOBERR,
  output logic       AVEC,
  output logic       IODLatch,
  output logic       nAS_IOB,
  output logic       nUDS_IOB,
  output logic       nLDS_IOB,
  output logic       RnW_IOB,
  output logic       nDoutOE,
  output logic       E,
  output logic       nVMA,
  input  logic       nDTACK,
  input  logic       nVPA,
  input  logic       nBERR
);

  logic       tick;
  logic [3:0] ecount;

  iob_eclk #(.DIV(DIV)) u_eclk (
    .CLK    (CLK),
    .RES    (RES),
    .tick   (tick),
    .E      (E),
    .ecount (ecount)
  );

  logic [1:0] dtack_sync, vpa_sync, berr_sync;
  logic       dtack_s, vpa_s, berr_s;

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      dtack_sync <= 2'b11;
      vpa_sync   <= 2'b11;
      berr_sync  <= 2'b11;
    end else begin
      dtack_sync <= {dtack_sync[0], nDTACK};
      vpa_sync   <= {vpa_sync[0], nVPA};
      berr_sync  <= {berr_sync[0], nBERR};
    end
  end

  assign dtack_s = ~dtack_sync[1];
  assign vpa_s   = ~vpa_sync[1];
  assign berr_s  = ~berr_sync[1];

  iob_state_t      state_q, state_d;
  logic            armed_q, armed_d;
  logic            rnw_q, rnw_d;
  logic            iack_q, iack_d;
  logic            err_q, err_d;
  logic            vpath_q, vpath_d;
  logic            abort_q, abort_d;
  logic [1:0]      be_q, be_d;
  logic [TO_W-1:0] tcnt_q, tcnt_d;
  logic            nas_d, nuds_d, nlds_d, rnw_iob_d, ndoe_d, nvma_d;
  logic            ioack_d, ioberr_d, avec_d, iodl_d;

  // NOTE: every variable gets a default first so no path through the case leaves a latch.
  always_comb begin
    state_d   = state_q;
    armed_d   = armed_q;
    rnw_d     = rnw_q;
    iack_d    = iack_q;
    err_d     = err_q;
    vpath_d   = vpath_q;
    abort_d   = abort_q;
    be_d      = be_q;
    tcnt_d    = tcnt_q;
    nas_d     = nAS_IOB;
    nuds_d    = nUDS_IOB;
    nlds_d    = nLDS_IOB;
    rnw_iob_d = RnW_IOB;
    ndoe_d    = nDoutOE;
    nvma_d    = nVMA;
    ioack_d   = 1'b0;
    ioberr_d  = 1'b0;
    avec_d    = 1'b0;
    iodl_d    = 1'b0;

    // The FSB may abandon the access; the IOB cycle still completes but reports nothing.
    if (state_q != ST_IDLE && !IOREQ) abort_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (!IOREQ) begin
          armed_d = 1'b1;
        end else if (armed_q && tick) begin
          state_d = ST_ADDR;
          armed_d = 1'b0;
          rnw_d   = RnW;
          be_d    = BE;
          iack_d  = IACK;
          err_d   = 1'b0;
          vpath_d = 1'b0;
          abort_d = 1'b0;
        end
      end
      ST_ADDR: if (tick) begin
        state_d = ST_STRB;
        nas_d   = 1'b0;
        if (!rnw_q) begin
          ndoe_d    = 1'b0;
          rnw_iob_d = 1'b0;
        end
      end
      ST_STRB: if (tick) begin
        state_d = ST_WAIT;
        nuds_d  = ~be_q[1];
        nlds_d  = ~be_q[0];
        tcnt_d  = '0;
      end
      ST_WAIT: if (tick) begin
        if (berr_s) begin
          state_d = ST_NEG;
          err_d   = 1'b1;
        end else if (dtack_s) begin
          state_d = ST_DATA;
        end else if (vpa_s) begin
          state_d = ST_VSYNC;
          vpath_d = 1'b1;
        end else if (tcnt_q == TO_W'(TIMEOUT)) begin
          state_d = ST_NEG;
          err_d   = 1'b1;
        end else if (tcnt_q != '1) begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      // VMA goes low on the tick that moves E into its VMA slot.
      ST_VSYNC: if (tick && ecount == VMA_SLOT - 4'd1) begin
        state_d = ST_VWAIT;
        nvma_d  = 1'b0;
      end
      ST_VWAIT: if (tick) begin
        if (berr_s) begin
          state_d = ST_NEG;
          err_d   = 1'b1;
        end else if (ecount == E_LAST) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: if (tick) begin
        state_d = ST_NEG;
        iodl_d  = rnw_q;
      end
      ST_NEG: if (tick) begin
        state_d   = ST_DONE;
        nas_d     = 1'b1;
        nuds_d    = 1'b1;
        nlds_d    = 1'b1;
        nvma_d    = 1'b1;
        ndoe_d    = 1'b1;
        rnw_iob_d = 1'b1;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (!abort_q && IOREQ) begin
          ioberr_d = err_q;
          ioack_d  = !err_q;
          avec_d   = !err_q && vpath_q && iack_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_q  <= ST_IDLE;
      armed_q  <= 1'b1;
      rnw_q    <= 1'b1;
      iack_q   <= 1'b0;
      err_q    <= 1'b0;
      vpath_q  <= 1'b0;
      abort_q  <= 1'b0;
      be_q     <= 2'b00;
      tcnt_q   <= '0;
      nAS_IOB  <= 1'b1;
      nUDS_IOB <= 1'b1;
      nLDS_IOB <= 1'b1;
      RnW_IOB  <= 1'b1;
      nDoutOE  <= 1'b1;
      nVMA     <= 1'b1;
      IOACK    <= 1'b0;
      IOBERR   <= 1'b0;
      AVEC     <= 1'b0;
      IODLatch <= 1'b0;
    end else begin
      state_q  <= state_d;
      armed_q  <= armed_d;
      rnw_q    <= rnw_d;
      iack_q   <= iack_d;
      err_q    <= err_d;
      vpath_q  <= vpath_d;
      abort_q  <= abort_d;
      be_q     <= be_d;
      tcnt_q   <= tcnt_d;
      nAS_IOB  <= nas_d;
      nUDS_IOB <= nuds_d;
      nLDS_IOB <= nlds_d;
      RnW_IOB  <= rnw_iob_d;
      nDoutOE  <= ndoe_d;
      nVMA     <= nvma_d;
      IOACK    <= ioack_d;
      IOBERR   <= ioberr_d;
      AVEC     <= avec_d;
      IODLatch <= iodl_d;
    end
  end

endmodule

// File: tb/tb_iob_bridge.sv
// Directed bench for iob_bridge (DIV=2, TIMEOUT=255); one task per scenario, timings in CLK cycles.
module tb_iob_bridge;

  logic       CLK = 1'b0;
  logic       RES = 1'b1;
  logic       IOREQ = 1'b0, IACK = 1'b0, RnW = 1'b1;
  logic [1:0] BE = 2'b11;
  logic       nDTACK = 1'b1, nVPA = 1'b1, nBERR = 1'b1;
  logic       IOACK, IOBERR, AVEC, IODLatch, nAS_IOB, nUDS_IOB, nLDS_IOB, RnW_IOB, nDoutOE, E, nVMA;

  int n_pass = 0;
  int n_chk  = 0;
  int g_ack  = 0;
  int g_err  = 0;

  int   r_as, r_as_rise, r_strb, r_dl, r_ack, r_err, r_vma_fall, r_vma_rise, r_e_rise, r_e_fall;
  int   r_nack, r_nerr;
  logic r_uds, r_lds, r_avec, r_avec_any, r_doe_ok, r_doe_low, r_rnw_strb, r_rnw_after;
  logic r_doe_after, r_second;

  iob_bridge #(.DIV(2), .TIMEOUT(255)) dut (
    .CLK(CLK), .RES(RES), .IOREQ(IOREQ), .IACK(IACK), .RnW(RnW), .BE(BE),
    .IOACK(IOACK), .IOBERR(IOBERR), .AVEC(AVEC), .IODLatch(IODLatch),
    .nAS_IOB(nAS_IOB), .nUDS_IOB(nUDS_IOB), .nLDS_IOB(nLDS_IOB), .RnW_IOB(RnW_IOB),
    .nDoutOE(nDoutOE), .E(E), .nVMA(nVMA),
    .nDTACK(nDTACK), .nVPA(nVPA), .nBERR(nBERR)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (IOACK) g_ack++;
    if (IOBERR) g_err++;
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  // Runs one FSB request and records when each IOB event is seen (k = CLK count from request).
  task automatic run_cycle(input logic rnw, input logic [1:0] be, input logic iack,
                           input int dtack_at, input int abort_at, input int hold, input int max_clk);
    int   k, stop_k;
    logic e_prev;
    r_as = -1; r_as_rise = -1; r_strb = -1; r_dl = -1; r_ack = -1; r_err = -1;
    r_vma_fall = -1; r_vma_rise = -1; r_e_rise = -1; r_e_fall = -1; r_nack = 0; r_nerr = 0;
    r_uds = 1'b1; r_lds = 1'b1; r_avec = 1'b0; r_avec_any = 1'b0; r_doe_ok = 1'b1;
    r_doe_low = 1'b0; r_rnw_strb = 1'b1; r_rnw_after = 1'b0; r_doe_after = 1'b0; r_second = 1'b0;
    @(negedge CLK);
    RnW = rnw; BE = be; IACK = iack; IOREQ = 1'b1;
    e_prev = E; k = 0; stop_k = -1;
    while (k < max_clk && !(stop_k >= 0 && k >= stop_k)) begin
      @(negedge CLK);
      k++;
      if (r_as < 0 && !nAS_IOB) r_as = k;
      if (r_as >= 0 && r_as_rise < 0 && nAS_IOB) begin
        r_as_rise = k; r_rnw_after = RnW_IOB; r_doe_after = nDoutOE;
      end
      if (r_as_rise >= 0 && !nAS_IOB) r_second = 1'b1;
      if (r_strb < 0 && (!nUDS_IOB || !nLDS_IOB)) begin
        r_strb = k; r_uds = nUDS_IOB; r_lds = nLDS_IOB; r_rnw_strb = RnW_IOB;
      end
      if (!nAS_IOB && nDoutOE) r_doe_ok = 1'b0;
      if (!nDoutOE) r_doe_low = 1'b1;
      if (IODLatch && r_dl < 0) r_dl = k;
      if (AVEC) r_avec_any = 1'b1;
      if (IOACK) begin r_nack++; r_ack = k; r_avec = AVEC; end
      if (IOBERR) begin r_nerr++; r_err = k; end
      if (r_vma_fall < 0 && !nVMA) r_vma_fall = k;
      if (r_vma_fall >= 0 && r_vma_rise < 0 && nVMA) r_vma_rise = k;
      if (r_vma_fall >= 0 && r_e_rise < 0 && E && !e_prev) r_e_rise = k;
      if (r_vma_fall >= 0 && r_e_fall < 0 && !E && e_prev) r_e_fall = k;
      e_prev = E;
      if (k == dtack_at) nDTACK = 1'b0;
      if (k == abort_at) IOREQ = 1'b0;
      if ((IOACK || IOBERR) && stop_k < 0) stop_k = k + 1 + hold;
    end
    IOREQ = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    n_chk++; if ({nAS_IOB, nUDS_IOB, nLDS_IOB, nDoutOE, nVMA, RnW_IOB} !== 6'b111111)
      $display("FAIL reset_strobes: got %b want 111111", {nAS_IOB, nUDS_IOB, nLDS_IOB, nDoutOE, nVMA, RnW_IOB});
    else n_pass++;
    n_chk++; if ({E, IOACK, IOBERR, AVEC, IODLatch} !== 5'b00000)
      $display("FAIL reset_pulses_e: got %b want 00000", {E, IOACK, IOBERR, AVEC, IODLatch});
    else n_pass++;
    RES = 1'b0;
  endtask

  task automatic test_eclk();
    int   t_r1, t_f, t_r2;
    logic prev;
    t_r1 = -1; t_f = -1; t_r2 = -1; prev = E;
    for (int k = 1; k <= 60; k++) begin
      @(negedge CLK);
      if (E && !prev) begin
        if (t_r1 < 0) t_r1 = k;
        else if (t_f >= 0 && t_r2 < 0) t_r2 = k;
      end
      if (!E && prev && t_r1 >= 0 && t_f < 0) t_f = k;
      prev = E;
    end
    n_chk++; if (t_r1 < 0 || t_f - t_r1 != 8)
      $display("FAIL e_high_time: got %0d want 8", t_f - t_r1); else n_pass++;
    n_chk++; if (t_r1 < 0 || t_r2 - t_r1 != 20)
      $display("FAIL e_period: got %0d want 20", t_r2 - t_r1); else n_pass++;
  endtask

  task automatic test_read_dtack();
    nDTACK = 1'b0;
    repeat (3) @(negedge CLK);
    run_cycle(1'b1, 2'b11, 1'b0, 0, 0, 0, 60);
    n_chk++; if (r_as < 3 || r_as > 4)
      $display("FAIL rd_as_delay: got %0d want 3..4", r_as); else n_pass++;
    n_chk++; if (r_strb - r_as != 2)
      $display("FAIL rd_strb_delay: got %0d want 2", r_strb - r_as); else n_pass++;
    n_chk++; if ({r_uds, r_lds} !== 2'b00)
      $display("FAIL rd_strobes: got %b want 00", {r_uds, r_lds}); else n_pass++;
    n_chk++; if (r_dl < 0 || r_dl - r_strb != 4)
      $display("FAIL rd_dlatch_delay: got %0d want 4", r_dl - r_strb); else n_pass++;
    n_chk++; if (r_ack - r_dl != 3)
      $display("FAIL rd_ack_after_dlatch: got %0d want 3", r_ack - r_dl); else n_pass++;
    n_chk++; if (r_ack < 12 || r_ack > 13)
      $display("FAIL rd_latency: got %0d want 12..13", r_ack); else n_pass++;
    n_chk++; if (r_nack != 1 || r_nerr != 0)
      $display("FAIL rd_pulses: got ack=%0d err=%0d want ack=1 err=0", r_nack, r_nerr); else n_pass++;
    n_chk++; if (r_doe_low !== 1'b0 || r_avec !== 1'b0)
      $display("FAIL rd_doe_avec: got doe_low=%b avec=%b want 0 0", r_doe_low, r_avec); else n_pass++;
    nDTACK = 1'b1;
  endtask

  task automatic test_write();
    nDTACK = 1'b1;
    repeat (3) @(negedge CLK);
    run_cycle(1'b0, 2'b10, 1'b0, 10, 0, 0, 80);
    n_chk++; if ({r_uds, r_lds} !== 2'b01)
      $display("FAIL wr_strobes: got %b want 01", {r_uds, r_lds}); else n_pass++;
    n_chk++; if (r_doe_ok !== 1'b1 || r_doe_low !== 1'b1)
      $display("FAIL wr_doe_whole_cycle: got ok=%b low=%b want 1 1", r_doe_ok, r_doe_low); else n_pass++;
    n_chk++; if (r_rnw_strb !== 1'b0)
      $display("FAIL wr_rnw_low: got %b want 0", r_rnw_strb); else n_pass++;
    n_chk++; if (r_rnw_after !== 1'b1 || r_doe_after !== 1'b1)
      $display("FAIL wr_neg_restore: got rnw=%b doe=%b want 1 1", r_rnw_after, r_doe_after); else n_pass++;
    n_chk++; if (r_nack != 1 || r_nerr != 0 || r_ack <= 10)
      $display("FAIL wr_ack: got ack=%0d err=%0d at %0d want one ack after 10", r_nack, r_nerr, r_ack);
    else n_pass++;
    n_chk++; if (r_dl != -1)
      $display("FAIL wr_no_dlatch: got %0d want -1", r_dl); else n_pass++;
    nDTACK = 1'b1;
  endtask

  task automatic test_vpa_read();
    logic prev;
    nVPA = 1'b0;
    prev = E;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (E && !prev) break;
      prev = E;
    end
    run_cycle(1'b1, 2'b11, 1'b0, 0, 0, 0, 100);
    n_chk++; if (r_nack != 1 || r_nerr != 0 || r_avec !== 1'b0)
      $display("FAIL vpa_ack: got ack=%0d err=%0d avec=%b want 1 0 0", r_nack, r_nerr, r_avec);
    else n_pass++;
    n_chk++; if (r_vma_fall < 0 || r_e_rise - r_vma_fall < 4 || r_e_rise - r_vma_fall > 6)
      $display("FAIL vpa_vma_slot: got %0d want 4..6 before E rise", r_e_rise - r_vma_fall); else n_pass++;
    n_chk++; if (r_e_fall < 0 || r_vma_rise <= r_e_fall)
      $display("FAIL vpa_vma_covers_e: got rise=%0d efall=%0d want rise after efall", r_vma_rise, r_e_fall);
    else n_pass++;
    n_chk++; if (r_ack <= r_e_fall || r_ack - r_e_fall > 8)
      $display("FAIL vpa_ack_after_efall: got %0d want 1..8", r_ack - r_e_fall); else n_pass++;
    n_chk++; if (r_vma_rise - r_vma_fall < 16 || r_vma_rise - r_vma_fall > 20)
      $display("FAIL vpa_vma_width: got %0d want 16..20", r_vma_rise - r_vma_fall); else n_pass++;
    n_chk++; if (r_dl < 0)
      $display("FAIL vpa_dlatch: got %0d want >=0", r_dl); else n_pass++;
    nVPA = 1'b1;
  endtask

  task automatic test_iack();
    nVPA = 1'b0;
    repeat (3) @(negedge CLK);
    run_cycle(1'b1, 2'b01, 1'b1, 0, 0, 0, 100);
    n_chk++; if (r_nack != 1 || r_avec !== 1'b1 || r_nerr != 0)
      $display("FAIL iack_avec: got ack=%0d avec=%b err=%0d want 1 1 0", r_nack, r_avec, r_nerr);
    else n_pass++;
    nVPA = 1'b1; nBERR = 1'b0; nDTACK = 1'b0;
    repeat (3) @(negedge CLK);
    run_cycle(1'b1, 2'b01, 1'b1, 0, 0, 0, 60);
    n_chk++; if (r_nerr != 1 || r_nack != 0)
      $display("FAIL iack_berr_priority: got err=%0d ack=%0d want 1 0", r_nerr, r_nack); else n_pass++;
    n_chk++; if (r_avec_any !== 1'b0)
      $display("FAIL iack_berr_no_avec: got %b want 0", r_avec_any); else n_pass++;
    nBERR = 1'b1; nDTACK = 1'b1;
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_abort();
    run_cycle(1'b1, 2'b11, 1'b0, 10, 6, 0, 40);
    n_chk++; if (r_nack != 0 || r_nerr != 0)
      $display("FAIL abort_suppressed: got ack=%0d err=%0d want 0 0", r_nack, r_nerr); else n_pass++;
    n_chk++; if (r_as < 0 || r_as_rise < 0)
      $display("FAIL abort_cycle_completes: got as=%0d rise=%0d want both >=0", r_as, r_as_rise);
    else n_pass++;
    nDTACK = 1'b1;
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_timeout();
    run_cycle(1'b1, 2'b11, 1'b0, 0, 0, 20, 600);
    n_chk++; if (r_nerr != 1 || r_nack != 0)
      $display("FAIL to_pulses: got err=%0d ack=%0d want 1 0", r_nerr, r_nack); else n_pass++;
    n_chk++; if (r_err - r_strb < 510 || r_err - r_strb > 520)
      $display("FAIL to_latency: got %0d want 510..520", r_err - r_strb); else n_pass++;
    n_chk++; if (r_as_rise < 0 || {nAS_IOB, nUDS_IOB, nLDS_IOB} !== 3'b111)
      $display("FAIL to_strobes_negated: got %b want 111", {nAS_IOB, nUDS_IOB, nLDS_IOB}); else n_pass++;
    n_chk++; if (r_second !== 1'b0)
      $display("FAIL to_no_rearm_while_held: got %b want 0", r_second); else n_pass++;
    nDTACK = 1'b0;
    repeat (3) @(negedge CLK);
    run_cycle(1'b1, 2'b11, 1'b0, 0, 0, 0, 60);
    n_chk++; if (r_nack != 1)
      $display("FAIL to_rearm_cycle: got ack=%0d want 1", r_nack); else n_pass++;
    run_cycle(1'b0, 2'b01, 1'b0, 0, 0, 0, 60);
    n_chk++; if (r_nack != 1 || {r_uds, r_lds} !== 2'b10)
      $display("FAIL back_to_back: got ack=%0d strobes=%b want 1 10", r_nack, {r_uds, r_lds}); else n_pass++;
    nDTACK = 1'b1;
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_reset_midcycle();
    int ack0, err0;
    @(negedge CLK);
    RnW = 1'b1; BE = 2'b11; IACK = 1'b0; IOREQ = 1'b1;
    repeat (12) @(negedge CLK);
    n_chk++; if ({nAS_IOB, nUDS_IOB, nLDS_IOB} !== 3'b000)
      $display("FAIL rst_pre_wait: got %b want 000", {nAS_IOB, nUDS_IOB, nLDS_IOB}); else n_pass++;
    ack0 = g_ack; err0 = g_err;
    #2 RES = 1'b1;
    #1;
    n_chk++; if ({nAS_IOB, nUDS_IOB, nLDS_IOB, nDoutOE, nVMA, RnW_IOB} !== 6'b111111)
      $display("FAIL rst_async_negate: got %b want 111111", {nAS_IOB, nUDS_IOB, nLDS_IOB, nDoutOE, nVMA, RnW_IOB});
    else n_pass++;
    IOREQ = 1'b0;
    repeat (4) @(negedge CLK);
    n_chk++; if (g_ack != ack0 || g_err != err0)
      $display("FAIL rst_no_pulse: got ack=%0d err=%0d want %0d %0d", g_ack, g_err, ack0, err0);
    else n_pass++;
    RES = 1'b0; nDTACK = 1'b0;
    repeat (3) @(negedge CLK);
    run_cycle(1'b1, 2'b11, 1'b0, 0, 0, 0, 60);
    n_chk++; if (r_nack != 1 || r_nerr != 0)
      $display("FAIL rst_fresh_cycle: got ack=%0d err=%0d want 1 0", r_nack, r_nerr); else n_pass++;
    nDTACK = 1'b1;
  endtask

  initial begin
    test_reset();
    test_eclk();
    test_read_dtack();
    test_write();
    test_vpa_read();
    test_iack();
    test_abort();
    test_timeout();
    test_reset_midcycle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
